// File: rtl/ifid_queue.sv
// ifid_queue: two-entry fetch-to-decode instruction queue with flush and a saturating flush counter
module ifid_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instruction,
    input  logic [31:0]      if_pc_plus_4,
    output logic             if_ready,
    output logic             id_valid,
    output logic [31:0]      id_instruction,
    output logic [31:0]      id_pc_plus_4,
    input  logic             id_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [1:0] FULL = DEPTH[1:0];
    logic [63:0]      mem_q [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             push, pop;
    // if_ready comes from registered count only, so decode never reaches fetch combinationally
    assign if_ready       = count_q != FULL;
    assign id_valid       = count_q != 2'd0;
    assign occupancy      = count_q;
    assign flush_count    = flush_count_q;
    assign id_instruction = id_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign id_pc_plus_4   = id_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
    assign push           = if_valid & if_ready & ~flush;
    assign pop            = id_valid & id_ready & ~flush;
    always_comb begin
        wr_ptr_d      = flush ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d      = flush ? 1'b0 : rd_ptr_q ^ pop;
        count_d       = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        flush_count_d = (flush && id_valid && flush_count_q != '1) ? flush_count_q + 1'b1 : flush_count_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            flush_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            flush_count_q <= flush_count_d;
            if (push) mem_q[wr_ptr_q] <= {if_pc_plus_4, if_instruction};
        end
    end
endmodule

// File: doc/ifid_queue.md
# ifid_queue

Two-entry instruction queue between the fetch stage (Ifetc32) and the decode stage of the Minisys-1A pipeline. It captures the {PC+4, instruction} pair presented by fetch, holds it until decode accepts it, and back-pressures fetch through `if_ready`, which drives the fetch unit's PCWrite. A flush input discards queued instructions on taken branches and interrupts, and a saturating counter records flushes that discarded valid work.

## Interface
Parameters:
- `DEPTH`, 2: queue entries; fixed at 2, pointers are 1 bit.
- `CNT_W`, 16: width of `flush_count`.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `if_valid`  in  1  fetch presents a valid instruction this cycle.
- `if_instruction`  in  32  instruction word from fetch.
- `if_pc_plus_4`  in  32  PC+4 of that instruction.
- `if_ready`  out  1  queue can accept; connects to fetch PCWrite.
- `id_valid`  out  1  head entry valid for decode.
- `id_instruction`  out  32  head instruction; 32'h0 when empty.
- `id_pc_plus_4`  out  32  head PC+4; 32'h0 when empty.
- `id_ready`  in  1  decode consumes head this cycle.
- `flush`  in  1  discard all entries (branch taken / interrupt).
- `occupancy`  out  2  entries held, 0..2.
- `flush_count`  out  CNT_W  flushes that discarded ≥1 entry, saturating.

## Operation
- Storage: 2 × 64-bit entries {pc_plus_4, instruction}; `wr_ptr`, `rd_ptr` (1 bit each, wrap 1→0), `count` (0..2).
- `if_ready` = (count < 2); depends on registered state only, never on `id_ready` (no combinational path decode→fetch).
- `id_valid` = (count != 0); `occupancy` = count.
- push = `if_valid` & `if_ready` & !`flush`: write entry at `wr_ptr`, advance `wr_ptr`.
- pop = `id_valid` & `id_ready` & !`flush`: advance `rd_ptr`.
- count update: push only +1; pop only −1; push and pop together unchanged.
- `id_valid`=0 forces `id_instruction`/`id_pc_plus_4` to 32'h0 (nop into decode).
- Flush: count←0, wr_ptr←0, rd_ptr←0; any same-cycle push or pop ignored; entry contents need not be cleared. If count != 0 before the edge, `flush_count` increments, holding at all-ones.
- Priority: reset > flush > push/pop.
- `if_valid` while `if_ready`=0: ignored, no state change; fetch must hold since PCWrite is low.
- `id_ready` while empty: ignored; count never underflows.

## Timing
- Reset (synchronous, rising edge with `reset`=1): count=0, pointers=0, `flush_count`=0; outputs then `if_ready`=1, `id_valid`=0, `id_instruction`=0, `id_pc_plus_4`=0, `occupancy`=0.
- Latency: push at edge N is visible at the head (`id_valid`=1) after edge N; no same-cycle bypass.
- Throughput: one instruction/cycle sustained at count=1 with push and pop every cycle.
- Full (count=2): `if_ready`=0 in the cycle after the second push; a pop at edge N reasserts `if_ready` after N.
- Fetch updates its PC on the falling edge, so `if_*` inputs are stable at the rising edge; PCWrite (`if_ready`) is registered-derived and stable before that falling edge.
- Flush at edge N: `id_valid`=0 and `if_ready`=1 after N; the first post-flush instruction, from the redirected PC, can be pushed at edge N+1.
- Reset asserted mid-operation: the queue is emptied at that edge regardless of `flush`, `if_valid`, or `id_ready`.

## Test plan
- Reset, then push {pc+4=0x4, instr=0x8C010000} with `id_ready`=0 -> after edge: `id_valid`=1, `id_instruction`=0x8C010000, `occupancy`=1, `if_ready`=1.
- Push 0x11, 0x22 with `id_ready`=0, then present 0x33 -> `occupancy`=2, `if_ready`=0, 0x33 not stored; pop twice -> heads 0x11 then 0x22, then `id_valid`=0, outputs 0.
- Stream 0x100..0x10F with `if_valid`=`id_ready`=1 every cycle -> decode sees 16 words in order, one per cycle, `occupancy` holds at 1, no loss or duplication across pointer wrap.
- Queue holding 2 entries; assert `flush` with `if_valid`=`id_ready`=1 -> `occupancy`=0, `flush_count`=1, pushed word discarded; flush on an empty queue -> `flush_count` stays 1.
- Force `flush_count` to 0xFFFE via 2 further discarding flushes past it -> reads 0xFFFF and holds.
- Assert `reset` together with `flush` and push at count=2 -> all outputs at reset values, `flush_count`=0.
